// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the memory access unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD : access size encodings
//   mau_state_e                     : request FSM states
//   access_bytes()                  : byte count of an access size (0 = reserved)
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mau_state_e;

  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mau_mem_array.sv
// mau_mem_array: byte storage organised as 32-bit words, big-endian lanes.
//   clk     : rising-edge clock (storage is never reset)
//   idx_i   : word index for both read and write
//   we_i    : byte-lane write enables; lane i = byte at address offset i
//   wdata_i : write data, lane i in bits [31-8i -: 8]
//   rdata_o : combinational read of the addressed word (pre-write value)
module mau_mem_array
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  localparam int WORDS = MEM_BYTES / 4,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [3:0]       we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[idx_i][31-8*i -: 8] <= wdata_i[31-8*i -: 8];
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit over a local byte memory.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   is_ld, is_st          : operation; neither set = no-op, both set = error
//   size, sign_ext        : 0 byte, 1 half, 2 word, 3 reserved; sign-extend loads
//   addr, op2             : byte address, right-justified store data
//   rsp_valid/rsp_ready   : response handshake, outputs held until taken
//   ld_result, rsp_err    : load data (0 for stores/errors), rejection flag
// Build option: define MAU_SUBWORD_EN to support byte/half accesses; otherwise
// only word accesses are legal and sign-extension logic is not built.
// Stores commit and loads capture at the accept edge; the response is then
// delayed by WAIT_CYCLES extra cycles.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES   = 4096,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_ld,
  input  logic              is_st,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       op2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       ld_result,
  output logic              rsp_err
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  // End-address arithmetic is one bit wider than the address and wide enough
  // to hold MEM_BYTES, so addr+bytes never wraps.
  localparam int EW = (ADDR_W + 1 > 34) ? ADDR_W + 1 : 34;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mau_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] ld_result_q;

  logic             accept;
  logic [2:0]       nbytes;
  logic [EW-1:0]    end_addr;
  logic             oob, misalign, size_bad, err_d;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       we_d, mem_we;
  logic [31:0]      wdata_d, ld_data_d, rdata;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // ---- request checks ----
  assign nbytes   = access_bytes(size);
  assign end_addr = EW'(addr) + EW'(nbytes);
  assign oob      = end_addr > EW'(MEM_BYTES);
  assign misalign = ((size == SZ_HALF) && addr[0]) ||
                    ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`ifdef MAU_SUBWORD_EN
  assign size_bad = (size == SZ_RSVD);
`else
  assign size_bad = (size != SZ_WORD);
  logic unused_sign_ext;
  assign unused_sign_ext = sign_ext;
`endif
  // A no-op never errors; checks only apply to real accesses.
  assign err_d = (is_ld || is_st) &&
                 ((is_ld && is_st) || size_bad || misalign || oob);

  // ---- lane steering (big-endian: lowest address = MSB) ----
  always_comb begin
    we_d      = 4'b0000;
    wdata_d   = op2;
    ld_data_d = 32'd0;
    case (size)
`ifdef MAU_SUBWORD_EN
      SZ_BYTE: begin
        we_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{op2[7:0]}};
        case (addr[1:0])
          2'd0:    ld_data_d[7:0] = rdata[31:24];
          2'd1:    ld_data_d[7:0] = rdata[23:16];
          2'd2:    ld_data_d[7:0] = rdata[15:8];
          default: ld_data_d[7:0] = rdata[7:0];
        endcase
        if (sign_ext) ld_data_d[31:8] = {24{ld_data_d[7]}};
      end
      SZ_HALF: begin
        we_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{op2[15:0]}};
        ld_data_d[15:0] = addr[1] ? rdata[15:0] : rdata[31:16];
        if (sign_ext) ld_data_d[31:16] = {16{ld_data_d[15]}};
      end
`endif
      SZ_WORD: begin
        we_d      = 4'b1111;
        ld_data_d = rdata;
      end
      default: ;
    endcase
  end

  assign mem_idx = IDX_W'(addr >> 2);
  assign mem_we  = (accept && is_st && !err_d) ? we_d : 4'b0000;

  mau_mem_array #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .clk     (clk),
    .idx_i   (mem_idx),
    .we_i    (mem_we),
    .wdata_i (wdata_d),
    .rdata_o (rdata)
  );

  // ---- request FSM with registered response outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_result_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            rsp_err_q   <= err_d;
            ld_result_q <= (is_ld && !err_d) ? ld_data_d : 32'd0;
            if (WAIT_CYCLES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign ld_result = ld_result_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 4096, meaning the byte-addressable storage size, a power of two, minimum 4.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the request address width.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 0, meaning the extra cycles between accept and response, range 0-15.
REQ-004 The block SHALL have one clock and synchronous active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-005 The block SHALL have these request ports: req_valid input 1 request present; req_ready output 1 block can accept.
REQ-006 The block SHALL have these operation ports: is_ld input 1 load; is_st input 1 store.
REQ-007 The block SHALL have these access-control ports: size input 2 access size (0 byte, 1 half, 2 word, 3 reserved); sign_ext input 1 sign-extend sub-word loads.
REQ-008 The block SHALL have these data ports: addr input ADDR_W byte address; op2 input 32 store data, right-justified.
REQ-009 The block SHALL have these response ports: rsp_valid output 1 response present; rsp_ready input 1 consumer accepts response.
REQ-010 The block SHALL have these result ports: ld_result output 32 load data; rsp_err output 1 request rejected.

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT and RESP, with req_ready=1 only in IDLE.
REQ-012 The block SHALL accept a request on a rising edge with req_valid&&req_ready; the request fields are sampled only at that edge.
REQ-013 On accept, the block SHALL go to WAIT if WAIT_CYCLES>0 (counter loads WAIT_CYCLES-1), else to RESP.
REQ-014 In WAIT, the block SHALL decrement the counter each cycle and enter RESP after the counter reaches 0; total latency accept-edge to rsp_valid=1 is 1+WAIT_CYCLES cycles.
REQ-015 In RESP, the block SHALL hold rsp_valid=1 with ld_result and rsp_err stable until rsp_ready=1, then return to IDLE on that edge; a new request is accepted no earlier than the following cycle.
REQ-016 The block SHALL use big-endian byte order: the lowest address holds the most significant byte of the accessed unit.
REQ-017 A store SHALL write its bytes at the accept edge: byte mem[addr]=op2[7:0]; half mem[addr]=op2[15:8], mem[addr+1]=op2[7:0]; word mem[addr..addr+3]=op2[31:24..7:0].
REQ-018 A load SHALL capture its data at the accept edge, right-justify it in ld_result, and zero-extend or (sign_ext=1) sign-extend it to 32 bits.
REQ-019 The store/ld_result for a store response SHALL be 0.
REQ-020 The block SHALL set rsp_err=1, suppress all memory writes and return ld_result=0 when: is_ld&&is_st; size=3; half with addr[0]=1; word with addr[1:0]!=0; or addr+access_bytes>MEM_BYTES (computed without ADDR_W overflow).
REQ-021 A request with is_ld=is_st=0 SHALL be a no-op: it completes with rsp_err=0 and ld_result=0.
REQ-022 A load immediately following a store to the same address SHALL return the stored data.

Reset
REQ-023 Reset SHALL force state IDLE, counter 0, rsp_valid=0, rsp_err=0 and ld_result=0; req_ready=1 in the cycle after reset deasserts.
REQ-024 Memory contents SHALL NOT be cleared by reset.
REQ-025 Reset during WAIT or RESP SHALL abandon the response; a store already committed at accept SHALL remain written.

Configuration
REQ-026 Macro MAU_SUBWORD_EN defined: byte and half sizes SHALL be supported as above.
REQ-027 Macro MAU_SUBWORD_EN undefined: only size=2 SHALL be legal, with size 0/1 treated as errors per REQ-020, and sign-extension logic absent.

Structure
REQ-028 Shared package mau_pkg SHALL hold the size encodings SZ_BYTE/SZ_HALF/SZ_WORD, the FSM state enum and the access_bytes function.
REQ-029 Sub-module mau_mem_array SHALL hold the byte storage with 4 byte-lane write enables and a 4-byte read port; mem_access_unit SHALL hold the FSM, decode, checks and lane steering.

Verification
REQ-030 Word store addr=0x10, op2=0xDEADBEEF, then word load 0x10 -> ld_result=0xDEADBEEF, and byte load 0x10 -> 0x000000DE.
REQ-031 Byte store addr=0x21, op2=0x80, then byte load sign_ext=1 -> 0xFFFFFF80; with sign_ext=0 -> 0x00000080; half load 0x20 -> the prior byte at 0x20 in [15:8] and 0x80 in [7:0].
REQ-032 Word store to addr=0x13, and word store to addr=MEM_BYTES-2 -> rsp_err=1 for each; a subsequent load of 0x10 is unchanged.
REQ-033 WAIT_CYCLES=3: accept at cycle N -> rsp_valid at N+4; rsp_ready held low 5 cycles -> outputs stable and req_ready=0 throughout.
REQ-034 Both is_ld and is_st asserted -> rsp_err=1 and no write; reset asserted in WAIT -> next cycle rsp_valid=0, and after reset release req_ready=1.
